// File: rtl/usb_ep_router.sv
// Routes SIE IN/OUT transactions to NUM_CH bulk endpoint channels (channel k = endpoint FIRST_ENDP+k),
// with per-endpoint halt, channel enables and full-packet IN gating with a short-packet flush timeout.
module usb_ep_router #(
  parameter int NUM_CH       = 2,
  parameter int FIRST_ENDP   = 1,
  parameter int FLUSH_CYCLES = 4800
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  usb_reset_i,
  input  logic [3:0]            sie_endp_i,
  input  logic                  sie_in_req_i,
  input  logic                  sie_in_ready_i,
  input  logic                  sie_in_data_ack_i,
  input  logic                  sie_out_ready_i,
  output logic [7:0]            sie_in_data_o,
  output logic                  sie_in_valid_o,
  output logic                  sie_in_nak_o,
  output logic                  sie_out_nak_o,
  output logic                  sie_stall_o,
  output logic                  hit_o,
  input  logic [NUM_CH-1:0]     ch_en_i,
  input  logic                  halt_set_i,
  input  logic                  halt_clr_i,
  input  logic [3:0]            halt_endp_i,
  output logic [NUM_CH-1:0]     halt_o,
  output logic [NUM_CH-1:0]     toggle_reset_o,
  input  logic [8*NUM_CH-1:0]   ch_in_data_i,
  input  logic [NUM_CH-1:0]     ch_in_valid_i,
  input  logic [NUM_CH-1:0]     ch_in_full_i,
  input  logic [NUM_CH-1:0]     ch_in_empty_i,
  input  logic [NUM_CH-1:0]     ch_out_nak_i,
  output logic [NUM_CH-1:0]     ch_in_req_o,
  output logic [NUM_CH-1:0]     ch_in_ready_o,
  output logic [NUM_CH-1:0]     ch_in_data_ack_o,
  output logic [NUM_CH-1:0]     ch_out_ready_o
);

  localparam int SELW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CW   = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(FLUSH_CYCLES);

  typedef enum logic [1:0] {ST_IDLE, ST_IN, ST_OUT} state_t;

  state_t             state_q;
  logic [SELW-1:0]    sel_q;
  logic [NUM_CH-1:0]  halt_q, rdy_q, flush_q, toggle_q, valid_prev_q;
  logic [CW-1:0]      cnt_q [NUM_CH];

  logic [NUM_CH-1:0]  hit, halt_match, in_busy;
  logic [7:0]         ch_data [NUM_CH];
  logic [SELW-1:0]    hit_idx;
  logic               any_hit;
  logic               sel_en;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign hit[gi]        = ch_en_i[gi] & (sie_endp_i == 4'(FIRST_ENDP + gi));
    assign halt_match[gi] = (halt_endp_i == 4'(FIRST_ENDP + gi));
    assign in_busy[gi]    = (state_q == ST_IN) && (sel_q == SELW'(gi));
    assign ch_data[gi]    = ch_in_data_i[8*gi +: 8];
  end

  always_comb begin
    hit_idx = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (hit[k]) hit_idx = SELW'(k);
    end
  end

  assign any_hit = |hit;
  assign sel_en  = ch_en_i[sel_q];

  // Disabling the selected channel aborts the transaction on the next edge.
  always_ff @(posedge clk_i) begin
    if (!rstn_i || usb_reset_i) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (sie_in_req_i && any_hit) begin
            state_q <= ST_IN;
            sel_q   <= hit_idx;
          end else if (sie_out_ready_i && any_hit) begin
            state_q <= ST_OUT;
            sel_q   <= hit_idx;
          end
        end
        ST_IN:   if (!sie_in_req_i || !sel_en) state_q <= ST_IDLE;
        ST_OUT:  if (!sie_out_ready_i || !sel_en) state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i || usb_reset_i) begin
      halt_q       <= '0;
      rdy_q        <= '0;
      flush_q      <= '0;
      toggle_q     <= '0;
      valid_prev_q <= '0;
      for (int k = 0; k < NUM_CH; k++) cnt_q[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        valid_prev_q[k] <= ch_in_valid_i[k];
        toggle_q[k]     <= halt_clr_i & ~halt_set_i & halt_match[k];
        if (!ch_en_i[k]) begin
          halt_q[k]  <= 1'b0;
          rdy_q[k]   <= 1'b0;
          flush_q[k] <= 1'b0;
          cnt_q[k]   <= '0;
        end else begin
          if (halt_set_i && halt_match[k])      halt_q[k] <= 1'b1;
          else if (halt_clr_i && halt_match[k]) halt_q[k] <= 1'b0;
          if (FLUSH_CYCLES == 0) begin
            flush_q[k] <= 1'b0;
            cnt_q[k]   <= '0;
            if (!in_busy[k]) rdy_q[k] <= ~ch_in_empty_i[k];
          end else begin
            // A partial packet that sits untouched for FLUSH_CYCLES is released as a short packet.
            if (ch_in_empty_i[k] || ch_in_full_i[k] || (ch_in_valid_i[k] && !valid_prev_q[k]))
              cnt_q[k] <= '0;
            else if (cnt_q[k] != CNT_MAX)
              cnt_q[k] <= cnt_q[k] + CW'(1);
            if (ch_in_empty_i[k] || ch_in_data_ack_o[k]) flush_q[k] <= 1'b0;
            else if (cnt_q[k] == CNT_MAX)                flush_q[k] <= 1'b1;
            if (!in_busy[k]) rdy_q[k] <= ch_in_full_i[k] | flush_q[k];
          end
        end
      end
    end
  end

  assign halt_o         = halt_q;
  assign toggle_reset_o = toggle_q;

  always_comb begin
    sie_in_data_o    = '0;
    sie_in_valid_o   = 1'b0;
    sie_in_nak_o     = 1'b0;
    sie_out_nak_o    = 1'b0;
    sie_stall_o      = 1'b0;
    hit_o            = 1'b0;
    ch_in_req_o      = '0;
    ch_in_ready_o    = '0;
    ch_in_data_ack_o = '0;
    ch_out_ready_o   = '0;
    case (state_q)
      ST_IN: begin
        hit_o = 1'b1;
        if (halt_q[sel_q]) begin
          sie_stall_o = 1'b1;
        end else begin
          ch_in_req_o[sel_q]      = sie_in_req_i;
          ch_in_ready_o[sel_q]    = sie_in_ready_i;
          ch_in_data_ack_o[sel_q] = sie_in_data_ack_i;
          if (rdy_q[sel_q]) begin
            sie_in_valid_o = ch_in_valid_i[sel_q];
            sie_in_data_o  = ch_data[sel_q];
          end else begin
            sie_in_nak_o = 1'b1;
          end
        end
      end
      ST_OUT: begin
        hit_o = 1'b1;
        if (halt_q[sel_q]) begin
          sie_stall_o = 1'b1;
        end else begin
          ch_out_ready_o[sel_q] = sie_out_ready_i;
          sie_out_nak_o         = ch_out_nak_i[sel_q];
        end
      end
      default: ;
    endcase
  end

endmodule
